generator_seq: RTL and testbench

//  Time-multiplexed, parametrised successor of the 2-layer combinational generator MLP.

---
 rtl/generator_seq_if.sv | 32 +++
 rtl/generator_seq.sv | 149 ++++++++++++++
 tb/tb_generator_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/generator_seq_if.sv
// generator_seq_if: handshake and data bus between the latent source, the generator and the image path.
//   master modport: drives in_valid, a_in, weights/biases and out_ready; observes in_ready, y, ovf, busy.
//   slave modport:  the generator side of the same bundle.
interface generator_seq_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2,
    parameter int N_HID = 3,
    parameter int N_OUT = 9
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [N_IN*WIDTH-1:0]        a_in;
    logic [N_IN*N_HID*WIDTH-1:0]  w_L2;
    logic [N_HID*WIDTH-1:0]       b_L2;
    logic [N_HID*N_OUT*WIDTH-1:0] w_L3;
    logic [N_OUT*WIDTH-1:0]       b_L3;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_OUT*WIDTH-1:0]       y;
    logic                         ovf;
    logic                         busy;

    modport master (
        output in_valid, a_in, w_L2, b_L2, w_L3, b_L3, out_ready,
        input  in_ready, out_valid, y, ovf, busy
    );

    modport slave (
        input  in_valid, a_in, w_L2, b_L2, w_L3, b_L3, out_ready,
        output in_ready, out_valid, y, ovf, busy
    );
endinterface

// File: rtl/generator_seq.sv
// generator_seq: time-multiplexed 2-layer MLP, hidden = ReLU(W2*a + b2), y = ACT(W3*hidden + b3),
// computed with a single shared signed MAC.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus_if : slave side of generator_seq_if (input handshake + latent vector, weights/biases,
//            output handshake + y, ovf saturation flag, busy while computing)
module generator_seq #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int N_IN    = 2,
    parameter int N_HID   = 3,
    parameter int N_OUT   = 9,
    parameter int GUARD   = 8,
    parameter int OUT_ACT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    generator_seq_if.slave bus_if
);
    localparam int AW   = WIDTH + GUARD;
    localparam int PW   = 2 * WIDTH;
    localparam int SW   = PW + 1;
    localparam int KMAX = N_IN > N_HID ? N_IN : N_HID;
    localparam int JMAX = N_HID > N_OUT ? N_HID : N_OUT;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int JW   = $clog2(JMAX + 1);
    localparam logic signed [AW-1:0]    ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0]    ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [AW-1:0]    ONE     = AW'(1) << FRAC;

    typedef enum logic [1:0] {IDLE, L2, L3, DONE} state_t;

    state_t                   state_q, state_d;
    logic [JW-1:0]            j_q, j_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [N_IN*WIDTH-1:0]    a_q, a_d;
    logic [N_HID*WIDTH-1:0]   hid_q, hid_d;
    logic [N_OUT*WIDTH-1:0]   y_q, y_d;
    logic                     ovf_q, ovf_d;

    logic                     in_l3, mac;
    int                       n_k, n_j, jj, j2, j3, k2, k3;
    logic signed [WIDTH-1:0]  w_s, x_s, b_s, wb;
    logic signed [PW-1:0]     w_e, x_e, prod, prod_sh;
    logic signed [SW-1:0]     base_s, sum_s;
    logic signed [AW-1:0]     acc_sat, relu_v, clip_v, act_v;
    logic                     clamp_hi, clamp_lo;

    // Step k < n_k is a MAC cycle; step k == n_k is the writeback cycle of neuron j.
    assign in_l3 = state_q == L3;
    assign n_k   = in_l3 ? N_HID : N_IN;
    assign n_j   = in_l3 ? N_OUT : N_HID;
    assign mac   = int'(k_q) < n_k;
    assign jj    = int'(j_q);
    // Per-layer indices are forced to 0 when unused so every select stays in range.
    assign j2    = in_l3 ? 0 : jj;
    assign j3    = in_l3 ? jj : 0;
    assign k2    = (!in_l3 && mac) ? int'(k_q) : 0;
    assign k3    = (in_l3 && mac) ? int'(k_q) : 0;

    assign w_s = in_l3 ? bus_if.w_L3[(N_HID*j3+k3)*WIDTH +: WIDTH] : bus_if.w_L2[(N_IN*j2+k2)*WIDTH +: WIDTH];
    assign x_s = in_l3 ? hid_q[k3*WIDTH +: WIDTH] : a_q[k2*WIDTH +: WIDTH];
    assign b_s = in_l3 ? bus_if.b_L3[j3*WIDTH +: WIDTH] : bus_if.b_L2[j2*WIDTH +: WIDTH];

    assign w_e     = PW'(w_s);
    assign x_e     = PW'(x_s);
    assign prod    = w_e * x_e;
    assign prod_sh = prod >>> FRAC;
    // The bias is folded into the first MAC of each neuron, so no separate load cycle is spent.
    assign base_s  = (k_q == '0) ? SW'(b_s) : SW'(acc_q);
    assign sum_s   = base_s + SW'(prod_sh);
    // Saturating accumulate: large products pin the accumulator instead of wrapping it.
    assign acc_sat = sum_s > SW'(ACC_MAX) ? ACC_MAX : sum_s < SW'(ACC_MIN) ? ACC_MIN : AW'(sum_s);

    assign relu_v   = acc_q < 0 ? '0 : acc_q;
    assign clip_v   = acc_q < 0 ? '0 : acc_q > ONE ? ONE : acc_q;
    assign act_v    = (!in_l3 || OUT_ACT == 1) ? relu_v : (OUT_ACT == 2) ? clip_v : acc_q;
    assign clamp_hi = act_v > AW'(W_MAX);
    assign clamp_lo = act_v < AW'(W_MIN);
    assign wb       = clamp_hi ? W_MAX : clamp_lo ? W_MIN : WIDTH'(act_v);

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        hid_d   = hid_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus_if.in_valid) begin
                a_d     = bus_if.a_in;
                ovf_d   = 1'b0;
                j_d     = '0;
                k_d     = '0;
                state_d = L2;
            end
            L2, L3: if (mac) begin
                acc_d = acc_sat;
                k_d   = k_q + 1'b1;
            end else begin
                if (in_l3) y_d[jj*WIDTH +: WIDTH] = wb;
                else hid_d[jj*WIDTH +: WIDTH] = wb;
                ovf_d = ovf_q | clamp_hi | clamp_lo;
                k_d   = '0;
                if (jj == n_j - 1) begin
                    j_d     = '0;
                    state_d = in_l3 ? DONE : L3;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: if (bus_if.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            hid_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            hid_q   <= hid_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus_if.in_ready  = rst_n && state_q == IDLE;
    assign bus_if.out_valid = state_q == DONE;
    assign bus_if.busy      = state_q == L2 || state_q == L3;
    assign bus_if.y         = y_q;
    assign bus_if.ovf       = ovf_q;
endmodule

// File: tb/tb_generator_seq.sv
// tb_generator_seq: directed bench for generator_seq with a reference MLP model (linear and clip outputs).
module tb_generator_seq;
    localparam int W = 32, F = 16, NI = 2, NH = 3, NO = 9;
    localparam int ONE = 65536;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    generator_seq_if #(.WIDTH(W), .N_IN(NI), .N_HID(NH), .N_OUT(NO)) gif ();
    generator_seq_if #(.WIDTH(W), .N_IN(NI), .N_HID(NH), .N_OUT(NO)) gif2 ();

    generator_seq #(.OUT_ACT(0)) dut  (.clk(clk), .rst_n(rst_n), .bus_if(gif));
    generator_seq #(.OUT_ACT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus_if(gif2));

    assign gif2.in_valid  = gif.in_valid;
    assign gif2.a_in      = gif.a_in;
    assign gif2.w_L2      = gif.w_L2;
    assign gif2.b_L2      = gif.b_L2;
    assign gif2.w_L3      = gif.w_L3;
    assign gif2.b_L3      = gif.b_L3;
    assign gif2.out_ready = gif.out_ready;

    int a [NI];
    int w2[NI*NH];
    int b2[NH];
    int w3[NH*NO];
    int b3[NO];
    int exp_y[NO], exp_y2[NO], cap_y[NO], cap_y2[NO];
    bit exp_ovf, exp_ovf2, exp_valid, cap_ovf;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact integer arithmetic per neuron, flooring each product, clamping at writeback.
    function automatic void model();
        longint h[NH];
        longint s, m;
        longint mx = 64'sh7FFF_FFFF;
        longint mn = -64'sh8000_0000;
        exp_ovf = 1'b0;
        for (int j = 0; j < NH; j++) begin
            s = b2[j];
            for (int k = 0; k < NI; k++) s += (longint'(w2[NI*j+k]) * longint'(a[k])) >>> F;
            if (s < 0) s = 0;
            if (s > mx) begin s = mx; exp_ovf = 1'b1; end
            h[j] = s;
        end
        exp_ovf2 = exp_ovf;
        for (int j = 0; j < NO; j++) begin
            s = b3[j];
            for (int k = 0; k < NH; k++) s += (longint'(w3[NH*j+k]) * h[k]) >>> F;
            m = s < 0 ? 0 : (s > ONE ? ONE : s);
            exp_y2[j] = int'(m);
            if (s > mx) begin s = mx; exp_ovf = 1'b1; end
            if (s < mn) begin s = mn; exp_ovf = 1'b1; end
            exp_y[j] = int'(s);
        end
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NI; k++) gif.a_in[k*W +: W] = a[k];
        for (int i = 0; i < NI*NH; i++) gif.w_L2[i*W +: W] = w2[i];
        for (int i = 0; i < NH; i++) gif.b_L2[i*W +: W] = b2[i];
        for (int i = 0; i < NH*NO; i++) gif.w_L3[i*W +: W] = w3[i];
        for (int i = 0; i < NO; i++) gif.b_L3[i*W +: W] = b3[i];
    endtask

    task automatic fill(input int a0, input int a1, input int wv2, input int bv2, input int wv3, input int bv3);
        a[0] = a0;
        a[1] = a1;
        foreach (w2[i]) w2[i] = wv2;
        foreach (b2[i]) b2[i] = bv2;
        foreach (w3[i]) w3[i] = wv3;
        foreach (b3[i]) b3[i] = bv3;
    endtask

    // One full job: accept, measure latency, capture outputs, optionally stall with noise, then drain.
    task automatic run_job(input int hold, input bit noise);
        int n;
        drive_inputs();
        model();
        @(negedge clk);
        n = 0;
        while (!gif.in_ready && n < 200) begin @(negedge clk); n++; end
        chk("accept_in_ready", int'(gif.in_ready), 1);
        gif.in_valid = 1'b1;
        @(posedge clk);
        #1 gif.in_valid = 1'b0;
        exp_valid = 1'b1;
        n = 0;
        while (!gif.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
            if (n == 20) chk("busy_mid_job", int'(gif.busy), 1);
        end
        chk("latency", n, 45);
        for (int j = 0; j < NO; j++) begin
            cap_y[j]  = int'(gif.y[j*W +: W]);
            cap_y2[j] = int'(gif2.y[j*W +: W]);
        end
        cap_ovf = gif.ovf;
        repeat (hold) begin
            @(negedge clk);
            gif.in_valid = noise;
            if (noise) gif.a_in = '1;
            chk("in_ready_while_done", int'(gif.in_ready), 0);
        end
        @(negedge clk);
        gif.out_ready = 1'b1;
        @(posedge clk);
        #1 gif.out_ready = 1'b0;
        gif.in_valid = 1'b0;
        exp_valid = 1'b0;
        chk("out_valid_dropped", int'(gif.out_valid), 0);
        @(negedge clk);
        chk("in_ready_after_drain", int'(gif.in_ready), 1);
        chk("not_busy_after_drain", int'(gif.busy), 0);
    endtask

    // Every cycle a result is presented, both DUTs must match the model and stay stable.
    always @(negedge clk) begin
        if (rst_n && gif.out_valid) begin
            chk("out_valid_expected", int'(exp_valid), 1);
            if (exp_valid) begin
                for (int j = 0; j < NO; j++) begin
                    chk($sformatf("y[%0d]", j), int'(gif.y[j*W +: W]), exp_y[j]);
                    chk($sformatf("y_clip[%0d]", j), int'(gif2.y[j*W +: W]), exp_y2[j]);
                end
                chk("ovf", int'(gif.ovf), int'(exp_ovf));
                chk("ovf_clip", int'(gif2.ovf), int'(exp_ovf2));
                chk("clip_valid", int'(gif2.out_valid), 1);
                chk("in_ready_low_done", int'(gif.in_ready), 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        gif.in_valid = 1'b0;
        gif.out_ready = 1'b0;
        exp_valid = 1'b0;
        fill(0, 0, 0, 0, 0, 0);
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_y0", int'(gif.y[0 +: W]), 0);
        chk("rst_out_valid", int'(gif.out_valid), 0);
        chk("rst_busy", int'(gif.busy), 0);
        chk("rst_ovf", int'(gif.ovf), 0);
        chk("rst_in_ready", int'(gif.in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", int'(gif.in_ready), 1);

        // Zero weights: outputs are the output biases.
        fill(ONE, 2*ONE, 0, 0, 0, 0);
        for (int j = 0; j < NO; j++) b3[j] = j << 16;
        run_job(0, 1'b0);
        chk("bias_y0", cap_y[0], 0);
        chk("bias_y5", cap_y[5], 5 << 16);
        chk("bias_y8", cap_y[8], 8 << 16);
        chk("bias_ovf", int'(cap_ovf), 0);

        // All-ones weights: hidden = 3.0, y = 9.0.
        fill(ONE, 2*ONE, ONE, 0, ONE, 0);
        run_job(0, 1'b0);
        chk("ones_y0", cap_y[0], 32'h0009_0000);
        chk("ones_y8", cap_y[8], 32'h0009_0000);
        chk("ones_clip_y3", cap_y2[3], ONE);

        // Reset in the middle of a job aborts it.
        drive_inputs();
        gif.in_valid = 1'b1;
        @(posedge clk);
        #1 gif.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_y4", int'(gif.y[4*W +: W]), 0);
            chk("midrst_out_valid", int'(gif.out_valid), 0);
            chk("midrst_busy", int'(gif.busy), 0);
            chk("midrst_in_ready", int'(gif.in_ready), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_after", int'(gif.in_ready), 1);
        repeat (60) @(negedge clk);
        chk("midrst_no_result", int'(gif.out_valid), 0);

        // Negative hidden bias: ReLU zeros hidden, y = b_L3 (-1.0), clip output 0.
        fill(ONE, 2*ONE, ONE, -5*ONE, ONE, -ONE);
        run_job(0, 1'b0);
        chk("relu_y4", cap_y[4], -ONE);
        chk("relu_clip_y4", cap_y2[4], 0);
        chk("relu_ovf", int'(cap_ovf), 0);

        // Hidden and output saturation.
        fill(30000*ONE, 30000*ONE, ONE, 0, ONE, 0);
        run_job(0, 1'b0);
        chk("sat_y0", cap_y[0], 32'h7FFF_FFFF);
        chk("sat_ovf", int'(cap_ovf), 1);
        chk("sat_clip_y0", cap_y2[0], ONE);

        // ovf is cleared by the next accepted job.
        fill(ONE, 2*ONE, ONE, 0, ONE, 0);
        run_job(0, 1'b0);
        chk("ovf_cleared", int'(cap_ovf), 0);

        // Stall 10 cycles with in_valid noise, then a back-to-back mixed-sign job.
        run_job(10, 1'b1);
        chk("stall_y2", cap_y[2], 32'h0009_0000);
        a[0] = 32'h0000_8000;
        a[1] = -32'h0001_8000;
        w2 = '{ONE, 2*ONE, -32'h8000, 3, 32'h12345, -ONE};
        b2 = '{ONE, 0, 32'h4000};
        foreach (w3[i]) w3[i] = (i % 2 == 0) ? (i + 1) * 32'h3000 : -(i + 1) * 32'h2000;
        foreach (b3[i]) b3[i] = i * 32'h1800 - ONE;
        run_job(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
